// File: rtl/fp_adder_normalize.sv
// Normalisation stage of the FP adder: carry right-shift or iterative left shift by up to SHIFT_STEP per cycle.
// Define FP_NORM_FTZ_EN to flush subnormal inputs and results to zero.
`ifndef FP32
`define FP32 0
`endif
`ifndef FP64
`define FP64 1
`endif
`ifndef ZERO
`define ZERO 2'b01
`endif
`ifndef INF
`define INF 2'b10
`endif
`ifndef NAN
`define NAN 2'b11
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN ((data_format == `FP64) ? 11 : 8)
`endif
`ifndef GET_MANTISSA_LEN
`define GET_MANTISSA_LEN ((data_format == `FP64) ? 52 : 23)
`endif
`ifndef GET_PROTECT_LEN
`define GET_PROTECT_LEN (3)
`endif

module fp_adder_normalize #(
  parameter int data_format = `FP32,
  parameter int SHIFT_STEP  = 4
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [1:0]                                          in_special,
  input  logic                                                in_sign,
  input  logic [`GET_EXP_LEN-1:0]                             in_exp,
  input  logic [`GET_MANTISSA_LEN+`GET_PROTECT_LEN+1:0]       in_mant,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [1:0]                                          out_special,
  output logic                                                out_sign,
  output logic [`GET_EXP_LEN-1:0]                             out_exp,
  output logic [`GET_MANTISSA_LEN+`GET_PROTECT_LEN:0]         out_mant
);

  localparam int E  = `GET_EXP_LEN;
  localparam int M  = `GET_MANTISSA_LEN;
  localparam int P  = `GET_PROTECT_LEN;
  localparam int W  = M + P + 2;
  localparam int H  = M + P;
  localparam int EW = E + 1;

  localparam logic [1:0]  SP_NORMAL = 2'b00;
  localparam logic [1:0]  SP_ZERO   = `ZERO;
  localparam logic [1:0]  SP_INF    = `INF;
  localparam logic [1:0]  SP_NAN    = `NAN;
  localparam logic [E:0]  EXP_ONE   = {{E{1'b0}}, 1'b1};
  localparam logic [E:0]  EXP_MAX   = {1'b0, {E{1'b1}}};
  localparam logic [E:0]  STEP_K    = EW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     special_q, special_d;
  logic           sign_q, sign_d;
  logic [E-1:0]   exp_q, exp_d;
  logic [H:0]     mant_q, mant_d;
  logic           out_valid_q, out_valid_d;

  logic           in_ready_s;
  logic           accept_s;
  logic [H:0]     src_mant_s;
  logic [E:0]     src_exp_s;
  logic [E:0]     lzc_s;
  logic [E:0]     lim_s;
  logic [E:0]     k_step_s;
  logic [E:0]     k_s;
  logic [H:0]     shifted_s;
  logic [E:0]     shifted_exp_s;
  logic           step_done_s;
  logic [1:0]     step_special_s;
  logic [E-1:0]   step_exp_s;
  logic [H:0]     step_mant_s;
  logic [E:0]     inc_exp_s;

  // Zeros above the leading one, counted from the hidden-bit position down.
  function automatic logic [E:0] lzc_f(input logic [H:0] m);
    logic [E:0] n;
    logic       found;
    n     = {(E+1){1'b0}};
    found = 1'b0;
    for (int i = H; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (m[i]) begin
        found = 1'b1;
      end else begin
        n = n + EXP_ONE;
      end
    end
    return n;
  endfunction

  assign in_ready_s  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign src_mant_s  = accept_s ? in_mant[H:0] : mant_q;
  assign src_exp_s   = accept_s ? {1'b0, in_exp} : {1'b0, exp_q};
  assign inc_exp_s   = {1'b0, in_exp} + EXP_ONE;

  // One left-shift step, bounded by leading zeros, step size and the exponent floor of 1.
  always_comb begin
    lzc_s         = lzc_f(src_mant_s);
    lim_s         = (src_exp_s > EXP_ONE) ? (src_exp_s - EXP_ONE) : {(E+1){1'b0}};
    k_step_s      = (lzc_s > STEP_K) ? STEP_K : lzc_s;
    k_s           = (k_step_s > lim_s) ? lim_s : k_step_s;
    shifted_s     = src_mant_s << k_s;
    shifted_exp_s = src_exp_s - k_s;
    step_done_s   = shifted_s[H] || (shifted_exp_s <= EXP_ONE);
    if (step_done_s && !shifted_s[H]) begin
`ifdef FP_NORM_FTZ_EN
      step_special_s = SP_ZERO;
      step_exp_s     = {E{1'b0}};
      step_mant_s    = {(H+1){1'b0}};
`else
      step_special_s = SP_NORMAL;
      step_exp_s     = {E{1'b0}};
      step_mant_s    = shifted_s;
`endif
    end else begin
      step_special_s = SP_NORMAL;
      step_exp_s     = shifted_exp_s[E-1:0];
      step_mant_s    = shifted_s;
    end
  end

  // Next-state and datapath update: classify on accept, otherwise iterate or hand off.
  always_comb begin
    state_d   = state_q;
    special_d = special_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    if (accept_s) begin
      sign_d = in_sign;
      if (in_special != SP_NORMAL) begin
        special_d = in_special;
        exp_d     = ((in_special == SP_INF) || (in_special == SP_NAN)) ? {E{1'b1}} : {E{1'b0}};
        mant_d    = {(H+1){1'b0}};
        state_d   = ST_DONE;
      end else if (in_mant == {W{1'b0}}) begin
        special_d = SP_ZERO;
        exp_d     = {E{1'b0}};
        mant_d    = {(H+1){1'b0}};
        state_d   = ST_DONE;
      end else if (in_mant[W-1]) begin
        if (inc_exp_s >= EXP_MAX) begin
          special_d = SP_INF;
          exp_d     = {E{1'b1}};
          mant_d    = {(H+1){1'b0}};
        end else begin
          special_d = SP_NORMAL;
          exp_d     = inc_exp_s[E-1:0];
          mant_d    = {in_mant[W-1:2], in_mant[1] | in_mant[0]};
        end
        state_d = ST_DONE;
      end else begin
        special_d = step_special_s;
        exp_d     = step_exp_s;
        mant_d    = step_mant_s;
        state_d   = step_done_s ? ST_DONE : ST_NORM;
      end
    end else begin
      case (state_q)
        ST_NORM: begin
          special_d = step_special_s;
          exp_d     = step_exp_s;
          mant_d    = step_mant_s;
          state_d   = step_done_s ? ST_DONE : ST_NORM;
        end
        ST_DONE: begin
          state_d = out_ready ? ST_IDLE : ST_DONE;
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    out_valid_d = (state_d == ST_DONE);
  end

  // State and result registers; reset discards any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      special_q   <= 2'b00;
      sign_q      <= 1'b0;
      exp_q       <= {E{1'b0}};
      mant_q      <= {(H+1){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      special_q   <= special_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_special = special_q;
  assign out_sign    = sign_q;
  assign out_exp     = exp_q;
  assign out_mant    = mant_q;

endmodule

// File: tb/tb_fp_adder_normalize.sv
// Randomised self-checking bench for fp_adder_normalize (FP32, SHIFT_STEP=4) against an arithmetic reference model.
module tb_fp_adder_normalize;

  localparam int E    = 8;
  localparam int M    = 23;
  localparam int P    = 3;
  localparam int W    = M + P + 2;
  localparam int H    = M + P;
  localparam int STEP = 4;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_special;
  logic         in_sign;
  logic [E-1:0] in_exp;
  logic [W-1:0] in_mant;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_special;
  logic         out_sign;
  logic [E-1:0] out_exp;
  logic [H:0]   out_mant;

  int checks;
  int failures;

  fp_adder_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_special  (in_special),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_special (out_special),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Result and extra latency (edges after the accept edge) from plain integer arithmetic.
  task automatic ref_model(input logic [1:0] sp, input logic [E-1:0] ex, input logic [W-1:0] mt,
                           output logic [1:0] e_sp, output logic [E-1:0] e_ex,
                           output logic [H:0] e_mt, output int e_lat);
    int ei, pos, l, lim, s;
    logic [W-1:0] m2;
    e_lat = 0;
    if (sp != SP_NORMAL) begin
      e_sp = sp;
      e_ex = (sp == SP_ZERO) ? 8'h00 : 8'hFF;
      e_mt = '0;
    end else if (mt == '0) begin
      e_sp = SP_ZERO;
      e_ex = 8'h00;
      e_mt = '0;
    end else if (mt[W-1]) begin
      ei = int'(ex) + 1;
      if (ei >= 255) begin
        e_sp = SP_INF;
        e_ex = 8'hFF;
        e_mt = '0;
      end else begin
        e_sp = SP_NORMAL;
        e_ex = ei[E-1:0];
        m2   = (mt >> 1) | (mt & W'(1));
        e_mt = m2[H:0];
      end
    end else begin
      pos = 0;
      for (int i = 0; i < W; i++) if (mt[i]) pos = i;
      l   = H - pos;
      lim = (int'(ex) >= 1) ? int'(ex) - 1 : 0;
      s   = (l < lim) ? l : lim;
      m2  = mt << s;
      e_lat = (s == 0) ? 0 : (s + STEP - 1) / STEP - 1;
      if (s == l) begin
        e_sp = SP_NORMAL;
        e_ex = E'(int'(ex) - s);
        e_mt = m2[H:0];
      end else begin
`ifdef FP_NORM_FTZ_EN
        e_sp = SP_ZERO;
        e_ex = 8'h00;
        e_mt = '0;
`else
        e_sp = SP_NORMAL;
        e_ex = 8'h00;
        e_mt = m2[H:0];
`endif
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] sp, input logic sg,
                        input logic [E-1:0] ex, input logic [W-1:0] mt);
    logic [1:0] e_sp;
    logic [E-1:0] e_ex;
    logic [H:0] e_mt;
    int e_lat;
    int n;
    ref_model(sp, ex, mt, e_sp, e_ex, e_mt, e_lat);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_special = sp;
    in_sign    = sg;
    in_exp     = ex;
    in_mant    = mt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      check_val({tag, "_busy"}, 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'(e_lat));
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_special"}, 64'(out_special), 64'(e_sp));
    check_val({tag, "_sign"}, 64'(out_sign), 64'(sg));
    check_val({tag, "_exp"}, 64'(out_exp), 64'(e_ex));
    check_val({tag, "_mant"}, 64'(out_mant), 64'(e_mt));
    @(posedge clk);
    #1;
    check_val({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] mt;
    logic [W-1:0] mt_b;
    logic [1:0]   e_sp;
    logic [E-1:0] e_ex;
    logic [H:0]   e_mt;
    int           e_lat;
    logic [E-1:0] ex;
    int           kind;

    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_special = SP_NORMAL;
    in_sign    = 1'b0;
    in_exp     = '0;
    in_mant    = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_fields", {out_special, out_sign, out_exp, out_mant}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mt = '0; mt[H] = 1'b1;
    run_op("hidden", SP_NORMAL, 1'b0, 8'h80, mt);
    mt = '0; mt[W-1] = 1'b1; mt[W-2] = 1'b1; mt[0] = 1'b1;
    run_op("carry", SP_NORMAL, 1'b1, 8'h80, mt);
    run_op("carry_inf", SP_NORMAL, 1'b0, 8'hFE, mt);
    mt = '0; mt[H-10] = 1'b1;
    run_op("shift10", SP_NORMAL, 1'b0, 8'h80, mt);
    run_op("subnorm", SP_NORMAL, 1'b1, 8'h05, mt);
    run_op("in_subnorm", SP_NORMAL, 1'b0, 8'h00, mt);
    run_op("zero", SP_NORMAL, 1'b1, 8'h42, '0);
    run_op("nan", SP_NAN, 1'b1, 8'h12, mt);

    // Stall in DONE for five cycles, then hand off with a new operand on the same edge.
    mt = '0; mt[H] = 1'b1; mt[3] = 1'b1;
    ref_model(SP_NORMAL, 8'h80, mt, e_sp, e_ex, e_mt, e_lat);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_special = SP_NORMAL; in_sign = 1'b1;
    in_exp = 8'h80; in_mant = mt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_in_ready", 64'(in_ready), 64'd0);
      check_val("stall_hold", {out_special, out_exp, out_mant}, {e_sp, e_ex, e_mt});
      @(posedge clk);
      #1;
    end
    mt_b = '0; mt_b[W-1] = 1'b1; mt_b[1] = 1'b1;
    ref_model(SP_NORMAL, 8'h10, mt_b, e_sp, e_ex, e_mt, e_lat);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h10; in_mant = mt_b;
    #1;
    check_val("handoff_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("handoff_valid", 64'(out_valid), 64'd1);
    check_val("handoff_result", {out_special, out_sign, out_exp, out_mant}, {e_sp, 1'b0, e_ex, e_mt});
    @(posedge clk);
    #1;
    check_val("handoff_drain", 64'(out_valid), 64'd0);

    // Reset while the shifter is still iterating.
    mt = '0; mt[H-10] = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_exp = 8'h80; in_mant = mt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("pre_rst_busy", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 64'(out_valid), 64'd0);
    check_val("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_val("post_rst_no_beat", 64'(out_valid), 64'd0);
    end

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      ex   = E'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ex = E'($urandom_range(0, 12));
      mt   = W'({$urandom, $urandom});
      if (kind == 0) begin
        run_op("rnd_special", 2'($urandom_range(1, 3)), 1'($urandom), ex, mt);
      end else if (kind == 1) begin
        run_op("rnd_zero", SP_NORMAL, 1'($urandom), ex, '0);
      end else if (kind <= 3) begin
        mt[W-1] = 1'b1;
        run_op("rnd_carry", SP_NORMAL, 1'($urandom), ex, mt);
      end else begin
        mt[W-1] = 1'b0;
        mt[H]   = 1'b1;
        mt      = mt >> $urandom_range(0, H);
        run_op("rnd_left", SP_NORMAL, 1'($urandom), ex, mt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
